uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing one `uart_tx` byte transmitter between `N_REQ` byte-stream requesters, such as ROM message sources or status reporters. It sits between the requesters and the single `uart_tx` instance. A grant is locked for a whole message, which ends on the byte flagged `last`, so messages from different sources never interleave on the serial line. It issues the one-cycle start pulse and paces bytes from the transmitter's `busy` flag.

---
 rtl/uart_tx_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between N_REQ byte streams.
// Optional grant watchdog is compiled in with `define UART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// SEND  | owner g holds the grant; wait for its byte and an idle transmitter
// GAP   | one cycle after start while uart_tx raises busy
// WAIT  | byte in flight; wait for busy low, then next byte or release
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_data,
    input  logic [N_REQ-1:0]     i_last,
    output logic [N_REQ-1:0]     o_ack,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_busy,
    output logic                 o_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_served_q, last_served_d;
    logic              last_q, last_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [N_REQ-1:0]  ack_q, ack_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [SUM_W-1:0]  cand_sum;

    logic              sel_req;
    logic              sel_last;
    logic [7:0]        sel_byte;
    logic              accept;

    // Walk downward so the candidate closest after last_served is written last and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand_sum = {1'b0, last_served_q} + SUM_W'(i);
            if (cand_sum >= SUM_W'(N_REQ)) begin
                cand_sum = cand_sum - SUM_W'(N_REQ);
            end
            if (i_req[cand_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_byte = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                sel_req  = i_req[k];
                sel_last = i_last[k];
                sel_byte = i_data[8*k +: 8];
            end
        end
    end

    assign accept = (state_q == ST_SEND) && sel_req && !i_tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            wd_expired;

    // Down-counter runs only while the owner has no byte; a stalled transmitter is not a fault.
    assign wd_expired = (state_q == ST_SEND) && !sel_req && (wd_cnt_q == '0);

    always_comb begin
        wd_cnt_d  = WD_LOAD;
        timeout_d = wd_expired;
        if ((state_q == ST_SEND) && !accept) begin
            if (sel_req) begin
                wd_cnt_d = wd_cnt_q;
            end else if (wd_cnt_q != '0) begin
                wd_cnt_d = wd_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_cnt_q  <= WD_LOAD;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        last_d        = last_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        ack_d         = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    state_d           = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    tx_data_d      = sel_byte;
                    tx_start_d     = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    last_d         = sel_last;
                    state_d        = ST_GAP;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    grant_d       = '0;
                    last_served_d = owner_q;
                    state_d       = ST_IDLE;
                end
`endif
            end
            ST_GAP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_tx_busy) begin
                    if (last_q) begin
                        grant_d       = '0;
                        last_served_d = owner_q;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            last_served_q <= IDX_W'(N_REQ - 1);
            last_q        <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            ack_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            last_q        <= last_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            ack_q         <= ack_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_ack      = ack_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level round-robin model, a uart_tx busy model,
// and directed message scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             i_clock = 1'b0;
    logic             i_reset_n;
    logic [N-1:0]     i_req;
    logic [8*N-1:0]   i_data;
    logic [N-1:0]     i_last;
    logic [N-1:0]     o_ack;
    logic [N-1:0]     o_grant;
    logic [7:0]       o_tx_data;
    logic             o_tx_start;
    logic             i_tx_busy;
    logic             o_timeout;

    always #5 i_clock = ~i_clock;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_busy  (i_tx_busy),
        .o_timeout  (o_timeout)
    );

    typedef struct packed {
        logic [2:0] owner;
        logic       last;
        logic [7:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [8:0]  src_q[N][$];
    logic [N-1:0] pop_pend;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          frame_len = 5;
    int          bcnt = 0;
    logic        start_prev = 1'b0;
    int          model_last = N - 1;
    int          load_cyc = 0;
    int          timeout_seen = 0;

    int          start_cyc_log[$];
    logic [7:0]  start_data_log[$];
    logic [N-1:0] start_ack_log[$];
    logic [N-1:0] rise_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] log_data(input int i);
        if (i < start_data_log.size()) return 32'(start_data_log[i]);
        return 32'hdead;
    endfunction

    function automatic logic [31:0] log_ack(input int i);
        if (i < start_ack_log.size()) return 32'(start_ack_log[i]);
        return 32'hdead;
    endfunction

    function automatic logic [31:0] log_rise(input int i);
        if (i < rise_log.size()) return 32'(rise_log[i]);
        return 32'hdead;
    endfunction

    function automatic int log_cyc(input int i);
        if (i < start_cyc_log.size()) return start_cyc_log[i];
        return -1000;
    endfunction

    function automatic bit src_empty();
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        start_cyc_log.delete();
        start_data_log.delete();
        start_ack_log.delete();
        rise_log.delete();
    endtask

    // Message-level reference: whole messages, picked round-robin from the last owner.
    task automatic model_plan();
        logic [8:0] pq[N][$];
        logic [8:0] b;
        int         pick;
        int         cand;
        for (int k = 0; k < N; k++) pq[k] = src_q[k];
        for (int m = 0; m < 64; m++) begin
            pick = -1;
            for (int j = N; j >= 1; j--) begin
                cand = (model_last + j) % N;
                if (pq[cand].size() > 0) pick = cand;
            end
            if (pick < 0) break;
            do begin
                b = pq[pick].pop_front();
                exp_q.push_back(xfer_t'({3'(pick), b[8], b[7:0]}));
            end while (!b[8] && pq[pick].size() > 0);
            model_last = pick;
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        @(negedge i_clock);
        while (n < budget && !(exp_q.size() == 0 && o_grant == '0 && src_empty())) begin
            @(negedge i_clock);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    always @(posedge i_clock) cyc <= cyc + 1;

    // Requesters and uart_tx busy model.
    always @(posedge i_clock) begin
        logic [8:0] hd;
        #2;
        if (!i_reset_n) begin
            bcnt       = 0;
            i_tx_busy  = 1'b0;
            start_prev = 1'b0;
            pop_pend   = '0;
        end else begin
            if (start_prev) bcnt = frame_len;
            else if (bcnt > 0) bcnt--;
            i_tx_busy  = (bcnt > 0);
            start_prev = o_tx_start;
            for (int k = 0; k < N; k++) begin
                if (pop_pend[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
            pop_pend = o_ack;
        end
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                hd = src_q[k][0];
                i_req[k] = 1'b1;
                i_data[8*k +: 8] = hd[7:0];
                i_last[k] = hd[8];
            end else begin
                i_req[k] = 1'b0;
                i_data[8*k +: 8] = 8'h00;
                i_last[k] = 1'b0;
            end
        end
    end

    logic         c_start_prev = 1'b0;
    logic         c_b1 = 1'b0;
    logic         c_b2 = 1'b0;
    logic         c_last_done = 1'b1;
    logic [N-1:0] c_grant_prev = '0;
    xfer_t        c_x;

    always @(negedge i_clock) begin
        if (!i_reset_n) begin
            c_start_prev = 1'b0;
            c_b1         = 1'b0;
            c_b2         = 1'b0;
            c_last_done  = 1'b1;
            c_grant_prev = '0;
        end else begin
            chk("grant_onehot0", 32'($countones(o_grant) <= 1), 32'd1);
            chk("ack_onehot0", 32'($countones(o_ack) <= 1), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
            if (o_timeout) timeout_seen++;
`else
            chk("timeout_tied_low", 32'(o_timeout), 32'd0);
`endif
            if (o_tx_start) begin
                chk("start_back_to_back", 32'(c_start_prev), 32'd0);
                chk("busy_low_before_start", 32'(c_b1 | c_b2), 32'd0);
                chk("byte_expected_at_start", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    c_x = exp_q.pop_front();
                    chk("tx_data", 32'(o_tx_data), 32'(c_x.data));
                    chk("ack_owner", 32'(o_ack), 32'(N'(1) << c_x.owner));
                    chk("grant_at_start", 32'(o_grant), 32'(N'(1) << c_x.owner));
                    c_last_done = c_x.last;
                end
                start_cyc_log.push_back(cyc);
                start_data_log.push_back(o_tx_data);
                start_ack_log.push_back(o_ack);
            end else begin
                chk("ack_without_start", 32'(o_ack), 32'd0);
            end
            if (c_grant_prev == '0 && o_grant != '0) begin
                rise_log.push_back(o_grant);
                if (exp_q.size() > 0) chk("grant_rr_owner", 32'(o_grant), 32'(N'(1) << exp_q[0].owner));
                else chk("grant_with_nothing_pending", 32'(o_grant), 32'd0);
            end else if (c_grant_prev != '0 && o_grant == '0) begin
                chk("release_after_last", 32'(c_last_done | o_timeout), 32'd1);
            end else if (c_grant_prev != '0) begin
                chk("grant_locked", 32'(o_grant), 32'(c_grant_prev));
            end
            c_start_prev = o_tx_start;
            c_b2         = c_b1;
            c_b1         = i_tx_busy;
            c_grant_prev = o_grant;
        end
    end

    initial begin
        repeat (20000) @(posedge i_clock);
        $display("FAIL global_time_limit actual=%0d required=<20000 cycles", cyc);
        $fatal(1);
    end

    task automatic start_test(input int frame);
        @(posedge i_clock);
        #1;
        frame_len = frame;
        clear_logs();
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_req     = '0;
        i_data    = '0;
        i_last    = '0;
        i_tx_busy = 1'b0;
        pop_pend  = '0;
        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_start", 32'(o_tx_start), 32'd0);
        chk("rst_data", 32'(o_tx_data), 32'h00);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        @(negedge i_clock);
        i_reset_n = 1'b1;

        // "Hi" from requester 0
        start_test(5);
        src_q[0].push_back({1'b0, 8'h48});
        src_q[0].push_back({1'b1, 8'h69});
        model_plan();
        load_cyc = cyc;
        wait_done(200, "t1_done");
        chk("t1_start_count", 32'(start_data_log.size()), 32'd2);
        chk("t1_byte0", log_data(0), 32'h48);
        chk("t1_byte1", log_data(1), 32'h69);
        chk("t1_first_latency", 32'(log_cyc(0) - load_cyc), 32'd2);
        chk("t1_grant_count", 32'(rise_log.size()), 32'd1);
        chk("t1_grant", log_rise(0), 32'b0001);
        chk("t1_released", 32'(o_grant), 32'd0);

        // Requesters 2 and 0 both pending: grants alternate
        start_test(3);
        src_q[2].push_back({1'b0, 8'hA0});
        src_q[2].push_back({1'b1, 8'hA1});
        src_q[2].push_back({1'b1, 8'hA2});
        src_q[0].push_back({1'b1, 8'hB0});
        src_q[0].push_back({1'b0, 8'hB1});
        src_q[0].push_back({1'b1, 8'hB2});
        model_plan();
        wait_done(400, "t3_done");
        chk("t3_grant0", log_rise(0), 32'b0100);
        chk("t3_grant1", log_rise(1), 32'b0001);
        chk("t3_grant2", log_rise(2), 32'b0100);
        chk("t3_grant3", log_rise(3), 32'b0001);
        chk("t3_byte2", log_data(2), 32'hB0);

        // Requesters 1 and 2 simultaneous, 3 bytes each: no interleave
        start_test(4);
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b1, 8'h13});
        src_q[2].push_back({1'b0, 8'h21});
        src_q[2].push_back({1'b0, 8'h22});
        src_q[2].push_back({1'b1, 8'h23});
        model_plan();
        wait_done(400, "t2_done");
        for (int i = 0; i < 6; i++) begin
            chk("t2_ack_order", log_ack(i), (i < 3) ? 32'b0010 : 32'b0100);
            chk("t2_data_order", log_data(i), (i < 3) ? 32'(8'h11 + i) : 32'(8'h21 + i - 3));
        end

        // Busy stretched to 20 cycles per byte
        start_test(20);
        src_q[1].push_back({1'b0, 8'h31});
        src_q[1].push_back({1'b1, 8'h32});
        model_plan();
        wait_done(400, "t4_done");
        chk("t4_start_spacing", 32'(log_cyc(1) - log_cyc(0)), 32'd23);
        chk("t4_grant", log_rise(0), 32'b0010);

        // Reset in WAIT mid-message, then requester 0 wins over 2
        start_test(20);
        src_q[3].push_back({1'b0, 8'h41});
        src_q[3].push_back({1'b0, 8'h42});
        src_q[3].push_back({1'b1, 8'h43});
        model_plan();
        begin
            int n;
            n = 0;
            while (n < 100 && start_data_log.size() == 0) begin
                @(negedge i_clock);
                n++;
            end
            chk("t5_first_start_seen", 32'(n < 100), 32'd1);
        end
        repeat (6) @(negedge i_clock);
        i_reset_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(o_grant), 32'd0);
        chk("t5_rst_ack", 32'(o_ack), 32'd0);
        chk("t5_rst_start", 32'(o_tx_start), 32'd0);
        chk("t5_rst_data", 32'(o_tx_data), 32'h00);
        chk("t5_rst_timeout", 32'(o_timeout), 32'd0);
        exp_q.delete();
        for (int k = 0; k < N; k++) src_q[k].delete();
        pop_pend   = '0;
        model_last = N - 1;
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        start_test(5);
        src_q[2].push_back({1'b1, 8'h51});
        src_q[0].push_back({1'b1, 8'h52});
        model_plan();
        wait_done(200, "t5_done");
        chk("t5_first_grant", log_rise(0), 32'b0001);
        chk("t5_second_grant", log_rise(1), 32'b0100);
        chk("t5_byte0", log_data(0), 32'h52);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner drops its request after byte 1 of 3; watchdog hands over to requester 1
        start_test(5);
        timeout_seen = 0;
        src_q[0].push_back({1'b0, 8'h61});
        src_q[1].push_back({1'b0, 8'h71});
        src_q[1].push_back({1'b1, 8'h72});
        exp_q.push_back(xfer_t'({3'd0, 1'b0, 8'h61}));
        exp_q.push_back(xfer_t'({3'd1, 1'b0, 8'h71}));
        exp_q.push_back(xfer_t'({3'd1, 1'b1, 8'h72}));
        model_last = 1;
        wait_done(400, "t6_done");
        chk("t6_timeout_pulses", 32'(timeout_seen), 32'd1);
        chk("t6_grant0", log_rise(0), 32'b0001);
        chk("t6_grant1", log_rise(1), 32'b0010);
`endif

        repeat (3) @(posedge i_clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
